io_mmio_controller: RTL and testbench
=====================================

Name: io_mmio_controller

Overview:
- Memory-mapped I/O register block for region addr[31:28]==4'b1000; directly upstream of the load-data formatting stage, which consumes its registered read word as io_data_in.
- Provides a UART RX buffer FIFO, a UART TX holding register, and cycle/retired-instruction counters.
- Has one-cycle read latency to match the synchronous DMEM/BIOS RAMs.

Parameters:
RX_DEPTH, 8, UART RX FIFO entries (power of two, >=2)
RX_AW, 3, log2(RX_DEPTH)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
addr  in  32  byte address from execute stage
wdata  in  32  store data
wbe  in  4  store byte enables; all 0 = no store
re  in  1  load in execute stage
inst_retire  in  1  one instruction retired this cycle
rx_data  in  8  byte from UART receiver
rx_valid  in  1  rx_data valid
rx_ready  out  1  FIFO can accept byte
tx_data  out  8  byte to UART transmitter
tx_valid  out  1  tx_data valid
tx_ready  in  1  transmitter accepts byte
io_data_out  out  32  registered read data (to io_data_in)

Behaviour:
- Select: sel = (addr[31:28]==4'b1000); offset = addr[7:0] word-aligned (addr[1:0] ignored). No effect and no read data when sel=0.
- Register map (read value / write effect):
  - 0x00 status: {30'b0, rx_nonempty, tx_ready_bit}, where tx_ready_bit = !tx_valid; writes ignored.
  - 0x04 rx data: {24'b0, fifo head}, or 0 if empty; read with FIFO non-empty pops one entry. Writes ignored.
  - 0x08 tx data: reads 0; write with wbe[0]=1 loads wdata[7:0].
  - 0x10 cycle counter: read only.
  - 0x14 retired-instruction counter: read only.
  - 0x18: reads 0; write with any wbe bit clears both counters.
  - Other offsets: read 0, writes ignored.
- Read pipeline:
  - io_data_out <= (re & sel) ? map value : 32'b0 each cycle.
  - Value is sampled from state before this cycle's updates, so latency is exactly 1 cycle.
- re and any wbe bit both set in one cycle: the read is performed; the store is also performed.
- RX FIFO:
  - rx_ready = !full, combinational from state only.
  - Push on rx_valid & rx_ready.
  - Pop on re & sel & offset==0x04 & !empty.
  - Push and pop in the same cycle: both happen, count unchanged.
  - When full: no push; pop proceeds; rx_ready rises the next cycle.
  - When empty: the read returns 0 and no pop; a simultaneous push lands and is visible next cycle.
  - Pointers wrap modulo RX_DEPTH; an occupancy counter of RX_AW+1 bits distinguishes full from empty.
- TX holding register:
  - Write to 0x08 while tx_valid=0: tx_data <= wdata[7:0], tx_valid <= 1 next cycle.
  - tx_valid falls the cycle after tx_valid & tx_ready.
  - Write while tx_valid=1 is dropped (software polls the status register).
  - Write arriving in the same cycle as the handshake is also dropped.
  - tx_data stays stable while tx_valid=1.
- Counters:
  - 32-bit, wrap 0xFFFFFFFF->0.
  - cycle_cnt increments every cycle; inst_cnt increments when inst_retire=1.
  - A clear write overrides the increment that cycle: both counters read 0 on the next cycle.
- Reset (async, any time including mid-transfer):
  - FIFO emptied, rx_ready=1; tx_valid=0, tx_data=0.
  - Counters 0, io_data_out=0.
  - Pending pops and writes are lost.

Test Plan:
- Reset then idle 10 cycles, read 0x10 -> io_data_out = 10 one cycle after re (cycle count relative to reset release); read 0x00 -> 0x00000001.
- Push 0x41,0x42 via rx handshakes; read 0x00 -> 0x3; read 0x04 twice -> 0x41 then 0x42; third read -> 0x0; status bit1 then 0.
- Push 8 bytes with rx_valid held high -> rx_ready low after the 8th; 9th byte not accepted. Pop one -> rx_ready high the next cycle and the 9th byte accepted. Order preserved.
- Store 0x55 to 0x08 with tx_ready=0, then store 0x66 -> tx_data stays 0x55, tx_valid=1. Raise tx_ready -> tx_valid falls next cycle; 0x66 never appears.
- Pulse inst_retire 5 times, write 0x18 in the same cycle as a retire, read 0x14 next cycle -> 0. Preload cycle_cnt near wrap (force) -> 0xFFFFFFFF then 0.
- Assert rst mid-TX and with 3 FIFO entries -> outputs zero immediately, rx_ready=1; read 0x04 after release -> 0.

Source files
------------

// File: rtl/io_mmio_controller_if.sv
// -----------------------------------------------------------------------------
// io_mmio_controller_if
// Bus and UART-side signal bundle for the memory-mapped I/O register block.
//   master : core/bench side - drives addr, wdata, wbe, re, inst_retire,
//            rx_data, rx_valid, tx_ready; observes rx_ready, tx_data,
//            tx_valid, io_data_out.
//   slave  : io_mmio_controller side (directions mirrored).
// -----------------------------------------------------------------------------
interface io_mmio_controller_if;
  logic [31:0] addr;        // byte address from execute stage
  logic [31:0] wdata;       // store data
  logic [3:0]  wbe;         // store byte enables, all zero = no store
  logic        re;          // load in execute stage
  logic        inst_retire; // one instruction retired this cycle
  logic [7:0]  rx_data;     // byte from UART receiver
  logic        rx_valid;    // rx_data valid
  logic        rx_ready;    // RX FIFO can accept a byte
  logic [7:0]  tx_data;     // byte to UART transmitter
  logic        tx_valid;    // tx_data valid
  logic        tx_ready;    // transmitter accepts byte
  logic [31:0] io_data_out; // registered read word

  modport master (
    output addr, wdata, wbe, re, inst_retire, rx_data, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_valid, io_data_out
  );

  modport slave (
    input  addr, wdata, wbe, re, inst_retire, rx_data, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_valid, io_data_out
  );
endinterface

// File: rtl/io_mmio_controller.sv
// -----------------------------------------------------------------------------
// io_mmio_controller
// Memory-mapped I/O register block for the 0x8xxxxxxx region. Holds a UART RX
// byte FIFO, a UART TX holding register and free-running cycle / retired
// instruction counters. Reads have exactly one cycle of latency so the result
// lines up with the synchronous DMEM/BIOS RAMs feeding load formatting.
//
// Ports:
//   clk  - system clock, all state on rising edge
//   rst  - asynchronous active-high reset
//   bus  - io_mmio_controller_if.slave (CPU access, UART RX/TX, read data)
//
// Register map (word offsets, addr[1:0] ignored):
//   0x00 status   {30'b0, rx_nonempty, !tx_valid}         read only
//   0x04 rx data  {24'b0, fifo head} (pops when non-empty) read only
//   0x08 tx data  reads 0, store with wbe[0] loads byte
//   0x10 cycle counter                                    read only
//   0x14 retired-instruction counter                      read only
//   0x18 reads 0, any store clears both counters
// -----------------------------------------------------------------------------
module io_mmio_controller #(
  parameter int RX_DEPTH = 8,
  parameter int RX_AW    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  io_mmio_controller_if.slave  bus
);

  localparam logic [3:0]     IO_REGION  = 4'b1000;
  localparam logic [7:0]     OFF_STATUS = 8'h00;
  localparam logic [7:0]     OFF_RX     = 8'h04;
  localparam logic [7:0]     OFF_TX     = 8'h08;
  localparam logic [7:0]     OFF_CYCLE  = 8'h10;
  localparam logic [7:0]     OFF_INST   = 8'h14;
  localparam logic [7:0]     OFF_CLEAR  = 8'h18;
  localparam logic [RX_AW:0] CNT_FULL   = (RX_AW+1)'(RX_DEPTH);
  localparam logic [RX_AW:0] CNT_ZERO   = (RX_AW+1)'(0);
  localparam logic [RX_AW:0] CNT_ONE    = (RX_AW+1)'(1);
  localparam logic [RX_AW-1:0] PTR_ZERO = RX_AW'(0);
  localparam logic [RX_AW-1:0] PTR_ONE  = RX_AW'(1);

  // Decode and control strobes
  logic        sel_s;
  logic [7:0]  offset_s;
  logic        rd_en_s;
  logic        wr_en_s;
  logic        full_s;
  logic        empty_s;
  logic        push_s;
  logic        pop_s;
  logic        tx_load_s;
  logic        tx_done_s;
  logic        clr_s;
  logic [31:0] rd_word_s;

  // State
  logic [7:0]       rx_mem_r [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr_r;
  logic [RX_AW-1:0] rx_rd_ptr_r;
  logic [RX_AW:0]   rx_count_r;
  logic [7:0]       tx_data_r;
  logic             tx_valid_r;
  logic [31:0]      cycle_cnt_r;
  logic [31:0]      inst_cnt_r;
  logic [31:0]      io_data_out_r;

  // Address bits outside the word offset and upper store bytes are not decoded
  logic unused_s;
  assign unused_s = ^{bus.addr[27:8], bus.addr[1:0], bus.wdata[31:8]};

  // Address decode and per-cycle action strobes, all from current state
  always_comb begin
    sel_s     = (bus.addr[31:28] == IO_REGION);
    offset_s  = {bus.addr[7:2], 2'b00};
    rd_en_s   = bus.re & sel_s;
    wr_en_s   = sel_s & (bus.wbe != 4'b0000);
    full_s    = (rx_count_r == CNT_FULL);
    empty_s   = (rx_count_r == CNT_ZERO);
    push_s    = bus.rx_valid & ~full_s;
    pop_s     = rd_en_s & (offset_s == OFF_RX) & ~empty_s;
    tx_done_s = tx_valid_r & bus.tx_ready;
    // A store while the holding register is busy (including the handshake
    // cycle itself) is dropped; software polls status before storing.
    tx_load_s = wr_en_s & (offset_s == OFF_TX) & bus.wbe[0] & ~tx_valid_r;
    clr_s     = wr_en_s & (offset_s == OFF_CLEAR);
  end

  // Read mux: values come from pre-update state so the result is one cycle old
  always_comb begin
    rd_word_s = 32'h0000_0000;
    case (offset_s)
      OFF_STATUS: rd_word_s = {30'b0, ~empty_s, ~tx_valid_r};
      OFF_RX: begin
        if (!empty_s) begin
          rd_word_s = {24'h00_0000, rx_mem_r[rx_rd_ptr_r]};
        end else begin
          rd_word_s = 32'h0000_0000;
        end
      end
      OFF_CYCLE:  rd_word_s = cycle_cnt_r;
      OFF_INST:   rd_word_s = inst_cnt_r;
      default:    rd_word_s = 32'h0000_0000;
    endcase
  end

  // RX FIFO storage; contents need no reset because occupancy gates reads
  always_ff @(posedge clk) begin
    if (push_s) begin
      rx_mem_r[rx_wr_ptr_r] <= bus.rx_data;
    end
  end

  // RX FIFO pointers and occupancy; pointers wrap naturally at RX_DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wr_ptr_r <= PTR_ZERO;
      rx_rd_ptr_r <= PTR_ZERO;
      rx_count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        rx_wr_ptr_r <= rx_wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rx_rd_ptr_r <= rx_rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   rx_count_r <= rx_count_r + CNT_ONE;
        2'b01:   rx_count_r <= rx_count_r - CNT_ONE;
        default: rx_count_r <= rx_count_r;
      endcase
    end
  end

  // TX holding register; tx_data is only loaded while tx_valid is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
    end else if (tx_load_s) begin
      tx_data_r  <= bus.wdata[7:0];
      tx_valid_r <= 1'b1;
    end else if (tx_done_s) begin
      tx_valid_r <= 1'b0;
    end
  end

  // Cycle and retired-instruction counters; a clear store wins over increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_r <= 32'h0000_0000;
      inst_cnt_r  <= 32'h0000_0000;
    end else if (clr_s) begin
      cycle_cnt_r <= 32'h0000_0000;
      inst_cnt_r  <= 32'h0000_0000;
    end else begin
      cycle_cnt_r <= cycle_cnt_r + 32'h0000_0001;
      if (bus.inst_retire) begin
        inst_cnt_r <= inst_cnt_r + 32'h0000_0001;
      end
    end
  end

  // Registered read data; zero whenever no selected load is in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_data_out_r <= 32'h0000_0000;
    end else if (rd_en_s) begin
      io_data_out_r <= rd_word_s;
    end else begin
      io_data_out_r <= 32'h0000_0000;
    end
  end

  assign bus.rx_ready    = ~full_s;
  assign bus.tx_data     = tx_data_r;
  assign bus.tx_valid    = tx_valid_r;
  assign bus.io_data_out = io_data_out_r;

  io_mmio_controller_chk #(
    .RX_DEPTH (RX_DEPTH),
    .RX_AW    (RX_AW)
  ) u_chk (
    .clk        (clk),
    .rst        (rst),
    .rx_count   (rx_count_r),
    .rx_ready   (~full_s),
    .tx_valid   (tx_valid_r),
    .tx_ready   (bus.tx_ready),
    .tx_data    (tx_data_r)
  );

endmodule

// -----------------------------------------------------------------------------
// io_mmio_controller_chk
// Invariant checks for the I/O block: FIFO occupancy bound, rx_ready tracking
// fullness, TX data stability and single-cycle handshake completion.
// Ports: clk, rst, rx_count, rx_ready, tx_valid, tx_ready, tx_data.
// -----------------------------------------------------------------------------
module io_mmio_controller_chk #(
  parameter int RX_DEPTH = 8,
  parameter int RX_AW    = 3
) (
  input logic             clk,
  input logic             rst,
  input logic [RX_AW:0]   rx_count,
  input logic             rx_ready,
  input logic             tx_valid,
  input logic             tx_ready,
  input logic [7:0]       tx_data
);

  localparam logic [RX_AW:0] CNT_FULL = (RX_AW+1)'(RX_DEPTH);

  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    rx_count <= CNT_FULL);

  a_ready_full: assert property (@(posedge clk) disable iff (rst)
    rx_ready == (rx_count != CNT_FULL));

  a_tx_stable: assert property (@(posedge clk) disable iff (rst)
    (tx_valid && !tx_ready) |=> (tx_valid && $stable(tx_data)));

  a_tx_done: assert property (@(posedge clk) disable iff (rst)
    (tx_valid && tx_ready) |=> !tx_valid);

endmodule

// File: tb/tb_io_mmio_controller.sv
// -----------------------------------------------------------------------------
// tb_io_mmio_controller
// Directed bench for io_mmio_controller. Loads push their hand-computed
// expected read word into a queue; a monitor pops and compares one cycle after
// every selected load, and expects zero read data on all other cycles.
// -----------------------------------------------------------------------------
module tb_io_mmio_controller;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  logic [31:0] exp_q [$];

  io_mmio_controller_if bus ();

  io_mmio_controller #(
    .RX_DEPTH (8),
    .RX_AW    (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle, driven at the falling edge; selected loads queue an expectation
  task automatic bus_cycle(input logic r, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] wd, input logic [31:0] exp);
    @(negedge clk);
    bus.re    = r;
    bus.addr  = a;
    bus.wbe   = be;
    bus.wdata = wd;
    if (r && (a[31:28] == 4'b1000)) exp_q.push_back(exp);
  endtask

  task automatic idle();
    bus_cycle(1'b0, 32'h0000_0000, 4'h0, 32'h0000_0000, 32'h0000_0000);
  endtask

  // Monitor: a selected load seen at a rising edge yields data at the next falling edge
  initial begin
    logic        rd_seen;
    logic [31:0] e;
    forever begin
      @(posedge clk);
      rd_seen = !rst && bus.re && (bus.addr[31:28] == 4'b1000);
      @(negedge clk);
      if (rd_seen) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rd_unexpected: got 0x%08h, expected no read", bus.io_data_out);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", bus.io_data_out, e);
        end
      end else begin
        chk("rd_idle_zero", bus.io_data_out, 32'h0000_0000);
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_chk            = 0;
    n_fail           = 0;
    rst              = 1'b1;
    bus.addr         = 32'h0000_0000;
    bus.wdata        = 32'h0000_0000;
    bus.wbe          = 4'h0;
    bus.re           = 1'b0;
    bus.inst_retire  = 1'b0;
    bus.rx_data      = 8'h00;
    bus.rx_valid     = 1'b0;
    bus.tx_ready     = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_io_data_out", bus.io_data_out, 32'h0);
    chk("rst_rx_ready", {31'b0, bus.rx_ready}, 32'h1);
    chk("rst_tx_valid", {31'b0, bus.tx_valid}, 32'h0);
    chk("rst_tx_data", {24'b0, bus.tx_data}, 32'h0);
    rst = 1'b0;

    // Ten cycles after release the cycle counter reads 10
    repeat (9) idle();
    bus_cycle(1'b1, 32'h8000_0010, 4'h0, 32'h0, 32'd10);
    bus_cycle(1'b1, 32'h8000_0000, 4'h0, 32'h0, 32'h0000_0001);
    bus_cycle(1'b1, 32'h0000_0010, 4'h0, 32'h0, 32'h0); // unselected load

    // Two RX bytes, then pops in order
    idle(); bus.rx_valid = 1'b1; bus.rx_data = 8'h41;
    idle(); bus.rx_data = 8'h42;
    bus_cycle(1'b1, 32'h8000_0000, 4'h0, 32'h0, 32'h0000_0003); bus.rx_valid = 1'b0;
    bus_cycle(1'b1, 32'h0000_0004, 4'h0, 32'h0, 32'h0); // unselected: must not pop
    bus_cycle(1'b1, 32'h8000_0004, 4'h0, 32'h0, 32'h0000_0041);
    bus_cycle(1'b1, 32'h8000_0005, 4'h0, 32'h0, 32'h0000_0042); // addr[1:0] ignored
    bus_cycle(1'b1, 32'h8000_0004, 4'h0, 32'h0, 32'h0000_0000);
    bus_cycle(1'b1, 32'h8000_0000, 4'h0, 32'h0, 32'h0000_0001);

    // Fill the FIFO with rx_valid held high
    for (int i = 0; i < 8; i++) begin
      idle();
      chk("rx_ready_filling", {31'b0, bus.rx_ready}, 32'h1);
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'h10 + i[7:0];
    end
    idle(); chk("rx_ready_full", {31'b0, bus.rx_ready}, 32'h0); bus.rx_data = 8'h18;
    idle(); chk("rx_ready_held", {31'b0, bus.rx_ready}, 32'h0);
    bus_cycle(1'b1, 32'h8000_0004, 4'h0, 32'h0, 32'h0000_0010);
    chk("rx_ready_pop_cycle", {31'b0, bus.rx_ready}, 32'h0);
    idle(); chk("rx_ready_after_pop", {31'b0, bus.rx_ready}, 32'h1);
    idle(); chk("rx_ready_refull", {31'b0, bus.rx_ready}, 32'h0); bus.rx_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      bus_cycle(1'b1, 32'h8000_0004, 4'h0, 32'h0, 32'h10 + 32'(i));
    end
    bus_cycle(1'b1, 32'h8000_0004, 4'h0, 32'h0, 32'h0);

    // TX holding register
    bus.tx_ready = 1'b0;
    bus_cycle(1'b0, 32'h8000_0008, 4'b0001, 32'h0000_0055, 32'h0);
    bus_cycle(1'b0, 32'h8000_0008, 4'b0001, 32'h0000_0066, 32'h0);
    chk("tx_valid_loaded", {31'b0, bus.tx_valid}, 32'h1);
    chk("tx_data_loaded", {24'b0, bus.tx_data}, 32'h55);
    bus_cycle(1'b1, 32'h8000_0000, 4'h0, 32'h0, 32'h0000_0000);
    bus_cycle(1'b1, 32'h8000_0008, 4'h0, 32'h0, 32'h0000_0000);
    chk("tx_data_busy_drop", {24'b0, bus.tx_data}, 32'h55);
    bus_cycle(1'b0, 32'h8000_0008, 4'b0001, 32'h0000_0077, 32'h0); bus.tx_ready = 1'b1;
    chk("tx_valid_hs", {31'b0, bus.tx_valid}, 32'h1);
    idle(); bus.tx_ready = 1'b0;
    chk("tx_valid_fell", {31'b0, bus.tx_valid}, 32'h0);
    chk("tx_data_hs_drop", {24'b0, bus.tx_data}, 32'h55);
    bus_cycle(1'b0, 32'h8000_0008, 4'b0010, 32'h0000_00AB, 32'h0);
    idle(); chk("tx_no_byte0", {31'b0, bus.tx_valid}, 32'h0);
    bus_cycle(1'b0, 32'h8000_0008, 4'b0001, 32'h0000_0099, 32'h0);
    idle();
    chk("tx_valid_reload", {31'b0, bus.tx_valid}, 32'h1);
    chk("tx_data_reload", {24'b0, bus.tx_data}, 32'h99);
    bus.tx_ready = 1'b1;
    idle(); bus.tx_ready = 1'b0;
    chk("tx_valid_drained", {31'b0, bus.tx_valid}, 32'h0);

    // Counters: retire count, clear priority, read+store together, wrap
    for (int i = 0; i < 5; i++) begin
      idle(); bus.inst_retire = 1'b1;
    end
    bus_cycle(1'b1, 32'h8000_0014, 4'h0, 32'h0, 32'd5); bus.inst_retire = 1'b0;
    bus_cycle(1'b0, 32'h8000_0018, 4'b1000, 32'h0, 32'h0); bus.inst_retire = 1'b1;
    bus_cycle(1'b1, 32'h8000_0014, 4'h0, 32'h0, 32'h0); bus.inst_retire = 1'b0;
    bus_cycle(1'b1, 32'h8000_0010, 4'h0, 32'h0, 32'd1);
    bus_cycle(1'b1, 32'h8000_0018, 4'b0001, 32'h0, 32'h0);
    bus_cycle(1'b1, 32'h8000_0010, 4'h0, 32'h0, 32'd0);
    bus_cycle(1'b0, 32'h0000_0018, 4'hF, 32'h0, 32'h0); // unselected: no clear
    bus_cycle(1'b1, 32'h8000_0010, 4'h0, 32'h0, 32'd2);
    bus_cycle(1'b1, 32'h8000_0010, 4'h0, 32'h0, 32'hFFFF_FFFF);
    force dut.cycle_cnt_r = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_cnt_r;
    bus_cycle(1'b1, 32'h8000_0010, 4'h0, 32'h0, 32'h0000_0000);
    idle();

    // Reset mid-transfer with three FIFO entries
    idle(); bus.rx_valid = 1'b1; bus.rx_data = 8'hA1;
    idle(); bus.rx_data = 8'hA2;
    idle(); bus.rx_data = 8'hA3;
    bus_cycle(1'b0, 32'h8000_0008, 4'b0001, 32'h0000_00A5, 32'h0); bus.rx_valid = 1'b0;
    bus_cycle(1'b1, 32'h8000_0000, 4'h0, 32'h0, 32'h0000_0002);
    idle();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_io_data_out", bus.io_data_out, 32'h0);
    chk("mid_rst_rx_ready", {31'b0, bus.rx_ready}, 32'h1);
    chk("mid_rst_tx_valid", {31'b0, bus.tx_valid}, 32'h0);
    chk("mid_rst_tx_data", {24'b0, bus.tx_data}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus_cycle(1'b1, 32'h8000_0004, 4'h0, 32'h0, 32'h0);
    bus_cycle(1'b1, 32'h8000_0000, 4'h0, 32'h0, 32'h0000_0001);
    repeat (3) idle();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
